// File: rtl/alu_pkg.sv
// ============================================================================
//  alu_pkg : shared opcode, condition, state and NZCV constants for ALU issue
//  Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package alu_pkg;

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_MUL = 4'b0010;
   localparam logic [3:0] OP_CMP = 4'b1000;
   localparam logic [3:0] OP_NOP = 4'b1111;

   localparam logic [3:0] COND_EQ = 4'b0000;
   localparam logic [3:0] COND_NE = 4'b0001;
   localparam logic [3:0] COND_CS = 4'b0010;
   localparam logic [3:0] COND_CC = 4'b0011;
   localparam logic [3:0] COND_MI = 4'b0100;
   localparam logic [3:0] COND_PL = 4'b0101;
   localparam logic [3:0] COND_VS = 4'b0110;
   localparam logic [3:0] COND_VC = 4'b0111;
   localparam logic [3:0] COND_HI = 4'b1000;
   localparam logic [3:0] COND_LS = 4'b1001;
   localparam logic [3:0] COND_GE = 4'b1010;
   localparam logic [3:0] COND_LT = 4'b1011;
   localparam logic [3:0] COND_GT = 4'b1100;
   localparam logic [3:0] COND_LE = 4'b1101;
   localparam logic [3:0] COND_AL = 4'b1110;
   localparam logic [3:0] COND_NV = 4'b1111;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_EXEC = 2'd1;
   localparam logic [1:0] ST_WB   = 2'd2;
   localparam logic [1:0] ST_SKIP = 2'd3;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

endpackage

`default_nettype wire

// File: rtl/alu_cond_eval.sv
// ============================================================================
//  alu_cond_eval : evaluates a 4-bit condition code against {N,Z,C,V}
//  Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module alu_cond_eval
   import alu_pkg::*;
(
   input  logic [3:0] cond,
   input  logic [3:0] nzcv,
   output logic       pass
);

   logic w_n, w_z, w_c, w_v;

   assign w_n = nzcv[FLAG_N];
   assign w_z = nzcv[FLAG_Z];
   assign w_c = nzcv[FLAG_C];
   assign w_v = nzcv[FLAG_V];

   always_comb begin
      pass = 1'b1;
      case (cond)
         COND_EQ: pass = w_z;
         COND_NE: pass = ~w_z;
         COND_CS: pass = w_c;
         COND_CC: pass = ~w_c;
         COND_MI: pass = w_n;
         COND_PL: pass = ~w_n;
         COND_VS: pass = w_v;
         COND_VC: pass = ~w_v;
         COND_HI: pass = w_c & ~w_z;
         COND_LS: pass = ~w_c | w_z;
         COND_GE: pass = (w_n == w_v);
         COND_LT: pass = (w_n != w_v);
         COND_GT: pass = ~w_z & (w_n == w_v);
         COND_LE: pass = w_z | (w_n != w_v);
         default: pass = 1'b1;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
// ============================================================================
//  alu_issue_ctrl : single-issue sequencer for the shared ALU, NZCV and writeback
//  Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module alu_issue_ctrl
   import alu_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int MUL_LAT   = 3,
   parameter int OTHER_LAT = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        in_opcode,
   input  logic              in_s_bit,
   input  logic [3:0]        in_cond,
   input  logic [DATA_W-1:0] in_a,
   input  logic [DATA_W-1:0] in_b,
   input  logic [3:0]        in_rd,
   output logic [3:0]        alu_op,
   output logic              alu_s_bit,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   input  logic [DATA_W-1:0] alu_result,
   input  logic [3:0]        alu_flags,
   input  logic              flags_wr_en,
   input  logic [3:0]        flags_wr_data,
   output logic [3:0]        flags_q,
   output logic              wb_valid,
   output logic [3:0]        wb_rd,
   output logic [DATA_W-1:0] wb_data,
   output logic              skip_pulse
);

   localparam int c_max_lat = (MUL_LAT > OTHER_LAT) ? MUL_LAT : OTHER_LAT;
   localparam int c_cnt_w   = $clog2(c_max_lat + 1);
   localparam logic [c_cnt_w-1:0] c_mul_cnt   = c_cnt_w'(MUL_LAT);
   localparam logic [c_cnt_w-1:0] c_other_cnt = c_cnt_w'(OTHER_LAT);
   localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);

   logic [1:0]         r_state;
   logic [c_cnt_w-1:0] r_cnt;
   logic [3:0]         r_op;
   logic               r_s;
   logic [DATA_W-1:0]  r_a;
   logic [DATA_W-1:0]  r_b;
   logic [3:0]         r_rd;
   logic [3:0]         r_flags;
   logic [3:0]         r_wb_rd;
   logic [DATA_W-1:0]  r_wb_data;

   logic w_pass;
   logic w_fire;
   logic w_last;
   logic w_no_wb;
   logic w_alu_upd;

   alu_cond_eval u_cond_eval (
      .cond (in_cond),
      .nzcv (r_flags),
      .pass (w_pass)
   );

   assign w_fire    = in_valid & in_ready;
   assign w_last    = (r_state == ST_EXEC) && (r_cnt == c_cnt_one);
   assign w_no_wb   = (r_op == OP_CMP) || (r_op == OP_NOP);
   assign w_alu_upd = w_last & r_s & (r_op != OP_NOP);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_cnt     <= '0;
         r_op      <= '0;
         r_s       <= 1'b0;
         r_a       <= '0;
         r_b       <= '0;
         r_rd      <= '0;
         r_wb_rd   <= '0;
         r_wb_data <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_fire) begin
                  r_op <= in_opcode;
                  r_s  <= in_s_bit;
                  r_a  <= in_a;
                  r_b  <= in_b;
                  r_rd <= in_rd;
                  if (w_pass) begin
                     r_state <= ST_EXEC;
                     r_cnt   <= (in_opcode == OP_MUL) ? c_mul_cnt : c_other_cnt;
                  end else begin
                     r_state <= ST_SKIP;
                  end
               end
            end
            ST_EXEC: begin
               // The counter parks at 1; the final EXEC cycle is the sample point.
               if (w_last) begin
                  if (w_no_wb) begin
                     r_state <= ST_IDLE;
                  end else begin
                     r_state   <= ST_WB;
                     r_wb_data <= alu_result;
                     r_wb_rd   <= r_rd;
                  end
               end else begin
                  r_cnt <= r_cnt - c_cnt_one;
               end
            end
            ST_WB:   r_state <= ST_IDLE;
            ST_SKIP: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // ALU flag update takes priority over an external load on the same edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_flags <= 4'b0000;
      end else if (w_alu_upd) begin
         r_flags <= alu_flags;
      end else if (flags_wr_en) begin
         r_flags <= flags_wr_data;
      end
   end

   assign in_ready   = (r_state == ST_IDLE) & ~reset;
   assign alu_op     = r_op;
   assign alu_s_bit  = r_s;
   assign alu_a      = r_a;
   assign alu_b      = r_b;
   assign flags_q    = r_flags;
   assign wb_valid   = (r_state == ST_WB);
   assign wb_rd      = r_wb_rd;
   assign wb_data    = r_wb_data;
   assign skip_pulse = (r_state == ST_SKIP);

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
// ============================================================================
//  tb_alu_issue_ctrl : directed and randomized check of alu_issue_ctrl
//  Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_alu_issue_ctrl;

   localparam int DATA_W  = 32;
   localparam int MUL_LAT = 3;

   logic              clk = 1'b0;
   logic              reset;
   logic              in_valid;
   logic              in_ready;
   logic [3:0]        in_opcode;
   logic              in_s_bit;
   logic [3:0]        in_cond;
   logic [DATA_W-1:0] in_a;
   logic [DATA_W-1:0] in_b;
   logic [3:0]        in_rd;
   logic [3:0]        alu_op;
   logic              alu_s_bit;
   logic [DATA_W-1:0] alu_a;
   logic [DATA_W-1:0] alu_b;
   logic [DATA_W-1:0] alu_result;
   logic [3:0]        alu_flags;
   logic              flags_wr_en;
   logic [3:0]        flags_wr_data;
   logic [3:0]        flags_q;
   logic              wb_valid;
   logic [3:0]        wb_rd;
   logic [DATA_W-1:0] wb_data;
   logic              skip_pulse;

   int n_checks = 0;
   int n_errors = 0;

   logic [3:0]        m_flags;
   logic [3:0]        m_wb_rd;
   logic [DATA_W-1:0] m_wb_data;

   alu_issue_ctrl #(.DATA_W(DATA_W), .MUL_LAT(MUL_LAT), .OTHER_LAT(1)) dut (
      .clk           (clk),
      .reset         (reset),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_opcode     (in_opcode),
      .in_s_bit      (in_s_bit),
      .in_cond       (in_cond),
      .in_a          (in_a),
      .in_b          (in_b),
      .in_rd         (in_rd),
      .alu_op        (alu_op),
      .alu_s_bit     (alu_s_bit),
      .alu_a         (alu_a),
      .alu_b         (alu_b),
      .alu_result    (alu_result),
      .alu_flags     (alu_flags),
      .flags_wr_en   (flags_wr_en),
      .flags_wr_data (flags_wr_data),
      .flags_q       (flags_q),
      .wb_valid      (wb_valid),
      .wb_rd         (wb_rd),
      .wb_data       (wb_data),
      .skip_pulse    (skip_pulse)
   );

   always #5 clk = ~clk;

   // Stand-in ALU: result from opcode and operands, flags chosen by the test.
   function automatic logic [DATA_W-1:0] alu_model(input logic [3:0] op,
                                                    input logic [DATA_W-1:0] a,
                                                    input logic [DATA_W-1:0] b);
      if (op == 4'b0000)      return a + b;
      else if (op == 4'b0010) return a * b;
      else                    return a ^ b;
   endfunction

   assign alu_result = alu_model(alu_op, alu_a, alu_b);

   function automatic bit cond_ok(input logic [3:0] f, input logic [3:0] cond);
      bit n, z, c, v;
      {n, z, c, v} = f;
      case (cond)
         4'd0:  return z;
         4'd1:  return !z;
         4'd2:  return c;
         4'd3:  return !c;
         4'd4:  return n;
         4'd5:  return !n;
         4'd6:  return v;
         4'd7:  return !v;
         4'd8:  return c && !z;
         4'd9:  return !c || z;
         4'd10: return n == v;
         4'd11: return n != v;
         4'd12: return !z && (n == v);
         4'd13: return z || (n != v);
         default: return 1'b1;
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready;
      int n = 0;
      while (!in_ready && n < 20) begin
         tick();
         n++;
      end
      check("ready_timeout", 32'(in_ready), 32'd1);
   endtask

   task automatic idle_load(input logic [3:0] data);
      flags_wr_en   = 1'b1;
      flags_wr_data = data;
      tick();
      flags_wr_en = 1'b0;
      m_flags = data;
      check("idle_load_flags", 32'(flags_q), 32'(m_flags));
   endtask

   // Issues one instruction and follows it until the controller is idle again.
   task automatic issue(input logic [3:0] op, input logic s, input logic [3:0] cond,
                        input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                        input logic [3:0] rd, input logic [3:0] fl,
                        input bit collide, input logic [3:0] cdata);
      bit pass;
      int lat;
      bit has_wb;
      wait_ready();
      pass   = cond_ok(m_flags, cond);
      lat    = (op == 4'b0010) ? MUL_LAT : 1;
      has_wb = (op != 4'b1000) && (op != 4'b1111);
      in_valid  = 1'b1;
      in_opcode = op;
      in_s_bit  = s;
      in_cond   = cond;
      in_a      = a;
      in_b      = b;
      in_rd     = rd;
      alu_flags = fl;
      tick();
      in_valid = 1'b0;
      if (!pass) begin
         check("skip_pulse", 32'(skip_pulse), 32'd1);
         check("skip_no_wb", 32'(wb_valid), 32'd0);
         check("skip_not_ready", 32'(in_ready), 32'd0);
         tick();
         check("skip_pulse_end", 32'(skip_pulse), 32'd0);
      end else begin
         for (int i = 0; i < lat; i++) begin
            check("exec_not_ready", 32'(in_ready), 32'd0);
            check("exec_no_wb", 32'(wb_valid), 32'd0);
            check("exec_no_skip", 32'(skip_pulse), 32'd0);
            check("alu_op", 32'(alu_op), 32'(op));
            check("alu_s_bit", 32'(alu_s_bit), 32'(s));
            check("alu_a", alu_a, a);
            check("alu_b", alu_b, b);
            if (collide) begin
               flags_wr_en   = 1'b1;
               flags_wr_data = cdata;
            end
            tick();
            flags_wr_en = 1'b0;
         end
         if (s && op != 4'b1111) m_flags = fl;
         else if (collide)       m_flags = cdata;
         if (has_wb) begin
            m_wb_data = alu_model(op, a, b);
            m_wb_rd   = rd;
            check("wb_valid", 32'(wb_valid), 32'd1);
            check("wb_data", wb_data, m_wb_data);
            check("wb_rd", 32'(wb_rd), 32'(m_wb_rd));
            check("wb_not_ready", 32'(in_ready), 32'd0);
            tick();
         end
      end
      check("idle_ready", 32'(in_ready), 32'd1);
      check("idle_no_wb", 32'(wb_valid), 32'd0);
      check("flags_q", 32'(flags_q), 32'(m_flags));
      check("wb_data_hold", wb_data, m_wb_data);
      check("wb_rd_hold", 32'(wb_rd), 32'(m_wb_rd));
   endtask

   initial begin
      reset = 1'b1;
      in_valid = 1'b0;
      in_opcode = '0;
      in_s_bit = 1'b0;
      in_cond = '0;
      in_a = '0;
      in_b = '0;
      in_rd = '0;
      alu_flags = '0;
      flags_wr_en = 1'b0;
      flags_wr_data = '0;
      m_flags = 4'b0000;
      m_wb_rd = '0;
      m_wb_data = '0;

      repeat (3) tick();
      check("reset_ready_low", 32'(in_ready), 32'd0);
      reset = 1'b0;
      #1;
      check("reset_flags", 32'(flags_q), 32'd0);
      check("reset_wb_valid", 32'(wb_valid), 32'd0);
      check("reset_wb_data", wb_data, 32'd0);
      check("reset_wb_rd", 32'(wb_rd), 32'd0);
      check("reset_skip", 32'(skip_pulse), 32'd0);
      check("reset_alu_op", 32'(alu_op), 32'd0);
      check("reset_alu_a", alu_a, 32'd0);
      check("reset_ready", 32'(in_ready), 32'd1);

      // ADD then MUL, both unconditional
      issue(4'b0000, 1'b1, 4'b1110, 32'd5, 32'd7, 4'd3, 4'b0000, 1'b0, 4'b0000);
      issue(4'b0010, 1'b0, 4'b1110, 32'd6, 32'd7, 4'd4, 4'b0000, 1'b0, 4'b0000);

      // CMP sets Z; NE then skips, EQ executes
      issue(4'b1000, 1'b1, 4'b1110, 32'd9, 32'd9, 4'd1, 4'b0100, 1'b0, 4'b0000);
      issue(4'b0000, 1'b0, 4'b0001, 32'd1, 32'd2, 4'd5, 4'b0000, 1'b0, 4'b0000);
      issue(4'b0000, 1'b0, 4'b0000, 32'd3, 32'd4, 4'd6, 4'b0000, 1'b0, 4'b0000);

      // External load then condition checks against it; then a load racing an ALU update
      idle_load(4'b1001);
      issue(4'b0000, 1'b0, 4'b1010, 32'd10, 32'd20, 4'd7, 4'b0000, 1'b0, 4'b0000);
      issue(4'b0000, 1'b0, 4'b1011, 32'd11, 32'd21, 4'd8, 4'b0000, 1'b0, 4'b0000);
      issue(4'b0000, 1'b1, 4'b1110, 32'd12, 32'd22, 4'd9, 4'b0010, 1'b1, 4'b1001);

      // Reset during the second EXEC cycle of a MUL abandons it
      wait_ready();
      in_valid  = 1'b1;
      in_opcode = 4'b0010;
      in_s_bit  = 1'b1;
      in_cond   = 4'b1110;
      in_a      = 32'd3;
      in_b      = 32'd5;
      in_rd     = 4'd2;
      alu_flags = 4'b1111;
      tick();
      in_valid = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      m_flags = 4'b0000;
      m_wb_data = '0;
      m_wb_rd = '0;
      check("rst_mid_flags", 32'(flags_q), 32'd0);
      check("rst_mid_wb", 32'(wb_valid), 32'd0);
      check("rst_mid_ready", 32'(in_ready), 32'd1);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("rst_mid_no_wb", 32'(wb_valid), 32'd0);
      end

      // NOP with S set leaves flags alone
      idle_load(4'b0110);
      issue(4'b1111, 1'b1, 4'b1110, 32'd1, 32'd1, 4'd1, 4'b1111, 1'b0, 4'b0000);

      for (int k = 0; k < 200; k++) begin
         logic [3:0] op;
         if ($urandom_range(0, 5) == 0) idle_load(4'($urandom));
         case ($urandom_range(0, 4))
            0: op = 4'b0000;
            1: op = 4'b0010;
            2: op = 4'b1000;
            3: op = 4'b1111;
            default: op = 4'($urandom);
         endcase
         issue(op, 1'($urandom), 4'($urandom), $urandom, $urandom, 4'($urandom),
               4'($urandom), ($urandom_range(0, 5) == 0), 4'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
